// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcodes, state encodings and datapath select codes for multicycle_ctrl_fsm
package ctrl_pkg;

  localparam int OP_RTYPE = 0;
  localparam int OP_ADDI  = 1;
  localparam int OP_LW    = 2;
  localparam int OP_SW    = 3;
  localparam int OP_BEQ   = 4;
  localparam int OP_JMP   = 5;
  localparam int OP_HALT  = 6;
  localparam int OP_NOP   = 15;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXEC_R = 4'd2;
  localparam logic [3:0] S_EXEC_I = 4'd3;
  localparam logic [3:0] S_WB_ALU = 4'd4;
  localparam logic [3:0] S_ADDR   = 4'd5;
  localparam logic [3:0] S_MEM_RD = 4'd6;
  localparam logic [3:0] S_WB_MEM = 4'd7;
  localparam logic [3:0] S_MEM_WR = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [3:0] S_HALT   = 4'd11;

  typedef enum logic [3:0] {
    FETCH  = S_FETCH,
    DECODE = S_DECODE,
    EXEC_R = S_EXEC_R,
    EXEC_I = S_EXEC_I,
    WB_ALU = S_WB_ALU,
    ADDR   = S_ADDR,
    MEM_RD = S_MEM_RD,
    WB_MEM = S_WB_MEM,
    MEM_WR = S_MEM_WR,
    BRANCH = S_BRANCH,
    JUMP   = S_JUMP,
    HALT   = S_HALT
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/ctrl_mem_timer.sv
// rtl/ctrl_mem_timer.sv - memory wait-cycle counter; expire never asserts when MEM_TIMEOUT is 0
module ctrl_mem_timer #(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  logic [TW-1:0] timer_q, timer_d;

  assign expire = (MEM_TIMEOUT > 0) && (timer_q == TW'(MEM_TIMEOUT));

  // Holding at the limit keeps the counter from wrapping if the owner ignores expire.
  always_comb begin
    timer_d = timer_q;
    if (clr) begin
      timer_d = '0;
    end else if (en && !expire && (MEM_TIMEOUT > 0)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multicycle control unit; CTRL_PERF_CNT_EN adds cycle/instruction counters
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int OP_W          = 4,
  parameter int MEM_TIMEOUT   = 0,
  parameter int ILLEGAL_HALTS = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic            iord,
  output logic            ir_write,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic [1:0]      pc_src,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic            reg_write,
  output logic            mem_to_reg,
  output logic            halted,
  output logic            illegal_op,
  output logic            mem_fault,
  output logic [3:0]      state_dbg
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]     cycle_cnt,
  output logic [31:0]     instr_cnt
`endif
);

  state_e state_q, state_d;
  logic   fault_q, fault_d;
  logic   illegal_dec;
  logic   tmr_expire;
  logic   wait_state;

  // The branch condition is resolved in the datapath; zero is only passed through this interface.
  logic unused_zero;
  assign unused_zero = zero;

  assign wait_state = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);

  ctrl_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (state_d != state_q),
    .en     (wait_state && !mem_ready),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d     = state_q;
    fault_d     = fault_q;
    illegal_dec = 1'b0;
    case (state_q)
      FETCH, MEM_RD, MEM_WR: begin
        if (mem_ready) begin
          state_d = (state_q == FETCH)  ? DECODE :
                    (state_q == MEM_RD) ? WB_MEM : FETCH;
        end else if (tmr_expire) begin
          state_d = HALT;
          fault_d = 1'b1;
        end
      end
      DECODE: begin
        if      (opcode == OP_W'(OP_RTYPE)) state_d = EXEC_R;
        else if (opcode == OP_W'(OP_ADDI))  state_d = EXEC_I;
        else if (opcode == OP_W'(OP_LW))    state_d = ADDR;
        else if (opcode == OP_W'(OP_SW))    state_d = ADDR;
        else if (opcode == OP_W'(OP_BEQ))   state_d = BRANCH;
        else if (opcode == OP_W'(OP_JMP))   state_d = JUMP;
        else if (opcode == OP_W'(OP_HALT))  state_d = HALT;
        else if (opcode == OP_W'(OP_NOP))   state_d = FETCH;
        else begin
          illegal_dec = 1'b1;
          state_d     = (ILLEGAL_HALTS != 0) ? HALT : FETCH;
        end
      end
      EXEC_R, EXEC_I: state_d = WB_ALU;
      ADDR:           state_d = (opcode == OP_W'(OP_LW)) ? MEM_RD : MEM_WR;
      HALT:           state_d = HALT;
      default:        state_d = FETCH;
    endcase
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REGB;
    alu_op        = ALU_ADD;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    halted        = 1'b0;
    illegal_op    = 1'b0;
    mem_fault     = 1'b0;
    state_dbg     = 4'd0;
    if (!reset) begin
      state_dbg  = state_q;
      mem_fault  = fault_q;
      illegal_op = (state_q == DECODE) && illegal_dec;
      case (state_q)
        FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_ONE;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE: alu_src_b = SRCB_BOFF;
        EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        EXEC_I, ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        WB_ALU: reg_write = 1'b1;
        MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
        end
        BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_src        = PC_ALUOUT;
        end
        JUMP: begin
          pc_write = 1'b1;
          pc_src   = PC_JUMP;
        end
        HALT:    halted = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cyc_q, ins_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      if (state_q != HALT) cyc_q <= cyc_q + 32'd1;
      if (state_q == FETCH && state_d == DECODE) ins_q <= ins_q + 32'd1;
    end
  end

  assign cycle_cnt = reset ? 32'd0 : cyc_q;
  assign instr_cnt = reset ? 32'd0 : ins_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - scoreboard bench for multicycle_ctrl_fsm (MEM_TIMEOUT=4, ILLEGAL_HALTS=1)
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic       alu_src_a, reg_write, mem_to_reg, halted, illegal_op, mem_fault;
  logic [3:0] state_dbg;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.OP_W(4), .MEM_TIMEOUT(4), .ILLEGAL_HALTS(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .iord          (iord),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_src        (pc_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .halted        (halted),
    .illegal_op    (illegal_op),
    .mem_fault     (mem_fault),
    .state_dbg     (state_dbg)
`ifdef CTRL_PERF_CNT_EN
    ,
    .cycle_cnt     (cycle_cnt),
    .instr_cnt     (instr_cnt)
`endif
  );

  logic [21:0] obs;
  assign obs = {state_dbg, mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
                alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, halted, illegal_op, mem_fault};

  typedef struct {
    string       lbl;
    bit          rst;
    bit          rdy;
    logic [3:0]  op;
    logic [21:0] exp;
  } cyc_t;

  typedef struct {
    string       lbl;
    logic [21:0] exp;
  } exp_t;

  cyc_t stim_q[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [21:0] exp_out(input int st, input bit rdy, input logic [3:0] op, input bit flt);
    logic req = 0, we = 0, io = 0, irw = 0, pcw = 0, pwc = 0, a = 0, rw = 0, m2r = 0, hlt = 0, ill = 0;
    logic [1:0] pcs = 2'b00, srcb = 2'b00, aop = 2'b00;
    case (st)
      0:  begin req = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      1:  begin srcb = 2'b11; ill = !(op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd15}); end
      2:  begin a = 1; aop = 2'b10; end
      3:  begin a = 1; srcb = 2'b10; end
      4:  rw = 1;
      5:  begin a = 1; srcb = 2'b10; end
      6:  begin req = 1; io = 1; end
      7:  begin rw = 1; m2r = 1; end
      8:  begin req = 1; we = 1; io = 1; end
      9:  begin a = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; end
      10: begin pcw = 1; pcs = 2'b10; end
      11: hlt = 1;
      default: ;
    endcase
    return {4'(st), req, we, io, irw, pcw, pwc, pcs, a, srcb, aop, rw, m2r, hlt, ill, flt};
  endfunction

  function automatic bit rnd();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic cyc(input string lbl, input bit rst, input bit rdy, input logic [3:0] op,
                     input int st, input bit flt = 0);
    cyc_t c;
    c.lbl = lbl;
    c.rst = rst;
    c.rdy = rdy;
    c.op  = op;
    c.exp = rst ? 22'd0 : exp_out(st, rdy, op, flt);
    stim_q.push_back(c);
  endtask

  task automatic rst_cycles(input int n);
    for (int i = 0; i < n; i++) cyc("reset", 1, 1, 4'h0, 0);
  endtask

  // One instruction: fw fetch wait cycles, mw wait cycles in the data-memory state.
  task automatic instr(input string lbl, input logic [3:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) cyc(lbl, 0, 0, op, 0);
    cyc(lbl, 0, 1, op, 0);
    cyc(lbl, 0, rnd(), op, 1);
    case (op)
      4'd0: begin cyc(lbl, 0, rnd(), op, 2); cyc(lbl, 0, rnd(), op, 4); end
      4'd1: begin cyc(lbl, 0, rnd(), op, 3); cyc(lbl, 0, rnd(), op, 4); end
      4'd2: begin
        cyc(lbl, 0, rnd(), op, 5);
        for (int i = 0; i < mw; i++) cyc(lbl, 0, 0, op, 6);
        cyc(lbl, 0, 1, op, 6);
        cyc(lbl, 0, rnd(), op, 7);
      end
      4'd3: begin
        cyc(lbl, 0, rnd(), op, 5);
        for (int i = 0; i < mw; i++) cyc(lbl, 0, 0, op, 8);
        cyc(lbl, 0, 1, op, 8);
      end
      4'd4:  cyc(lbl, 0, rnd(), op, 9);
      4'd5:  cyc(lbl, 0, rnd(), op, 10);
      4'd15: ;
      default: for (int i = 0; i < 3; i++) cyc(lbl, 0, rnd(), op, 11);
    endcase
  endtask

  initial begin : monitor
    int idx = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq($sformatf("%s#%0d", e.lbl, idx), {10'd0, obs}, {10'd0, e.exp});
        idx++;
      end
    end
  end

  initial begin : driver
    cyc_t c;
    rst_cycles(3);
    instr("rtype", 4'd0, 0, 0);
    instr("addi", 4'd1, 1, 0);
    instr("lw_wait", 4'd2, 0, 2);
    instr("sw", 4'd3, 0, 0);
    instr("beq", 4'd4, 0, 0);
    instr("jmp", 4'd5, 0, 0);
    instr("nop", 4'd15, 0, 0);
    instr("lw_slow", 4'd2, 3, 3);
    cyc("midrst", 0, 0, 4'd3, 0);
    cyc("midrst", 0, 0, 4'd3, 0);
    rst_cycles(1);
    instr("sw_after", 4'd3, 0, 1);
    instr("illegal", 4'd7, 0, 0);
    rst_cycles(2);
    instr("halt_op", 4'd6, 0, 0);
    rst_cycles(1);
    for (int i = 0; i < 5; i++) cyc("fetch_tmo", 0, 0, 4'd0, 0);
    for (int i = 0; i < 3; i++) cyc("fetch_tmo", 0, rnd(), 4'd0, 11, 1);
    rst_cycles(1);
    instr("at_limit", 4'd15, 4, 0);
    cyc("wr_tmo", 0, 1, 4'd3, 0);
    cyc("wr_tmo", 0, 0, 4'd3, 1);
    cyc("wr_tmo", 0, 0, 4'd3, 5);
    for (int i = 0; i < 5; i++) cyc("wr_tmo", 0, 0, 4'd3, 8);
    for (int i = 0; i < 2; i++) cyc("wr_tmo", 0, rnd(), 4'd3, 11, 1);
    rst_cycles(1);
    instr("rtype_end", 4'd0, 0, 0);

    while (stim_q.size() > 0) begin
      c = stim_q.pop_front();
      @(posedge clk);
      #1;
      reset     = c.rst;
      mem_ready = c.rdy;
      opcode    = c.op;
      exp_q.push_back('{c.lbl, c.exp});
    end
    repeat (2) @(negedge clk);
    check_eq("drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
